// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants, FSM state encoding and pipeline-control payload for the
// pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned OPC_W       = 6;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;

  localparam logic [OPC_W-1:0] OPC_LW = 6'b100011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_RUN  = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and HI/LO
// multiply/divide occupancy tracking.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [OPC_W-1:0] ex_opcode,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             id_md_start,
  input  logic             id_md_is_div,
  input  logic             id_uses_hilo,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic             md_done
);

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] w_md_cnt_nxt;
  logic             w_load_use;
  logic             w_md_hazard;
  logic             w_md_accept;
  pipe_ctrl_t       w_ctrl;

  // Hazard detection; a LW targeting $0 never creates a dependency.
  always_comb begin
    w_load_use  = (ex_opcode == OPC_LW) && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
    w_md_hazard = (r_state == ST_MD_RUN) && (id_md_start || id_uses_hilo);
    w_md_accept = id_md_start && (r_state != ST_MD_RUN) &&
                  !w_load_use && !ex_branch_taken;
  end

  // Stall/flush decode, taken branch wins over any stall.
  always_comb begin
    w_ctrl.pc_we        = 1'b1;
    w_ctrl.if_id_we     = 1'b1;
    w_ctrl.if_id_flush  = 1'b0;
    w_ctrl.id_ex_bubble = 1'b0;
    if (ex_branch_taken) begin
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_bubble = 1'b1;
    end else if (w_load_use || w_md_hazard) begin
      w_ctrl.pc_we        = 1'b0;
      w_ctrl.if_id_we     = 1'b0;
      w_ctrl.id_ex_bubble = 1'b1;
    end
  end

  // Next state; a running operation is never aborted by a younger branch.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      ST_IDLE, ST_MD_DONE: begin
        if (w_md_accept) begin
          w_state_nxt  = ST_MD_RUN;
          w_md_cnt_nxt = id_md_is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
        end else begin
          w_state_nxt  = ST_IDLE;
          w_md_cnt_nxt = '0;
        end
      end
      ST_MD_RUN: begin
        if (r_md_cnt == '0) begin
          w_state_nxt = ST_MD_DONE;
        end else begin
          w_md_cnt_nxt = r_md_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  assign pc_we        = w_ctrl.pc_we;
  assign if_id_we     = w_ctrl.if_id_we;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_bubble = w_ctrl.id_ex_bubble;
  assign md_busy      = (r_state == ST_MD_RUN);
  assign md_done      = (r_state == ST_MD_DONE);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scenario bench for pipe_stall_ctrl: per-cycle expected control vectors are
// queued as stimulus is applied and compared against the outputs mid-cycle.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done}
  localparam logic [5:0] E_N  = 6'b110000;
  localparam logic [5:0] E_ST = 6'b000100;
  localparam logic [5:0] E_FL = 6'b111100;
  localparam logic [5:0] E_B  = 6'b000010;
  localparam logic [5:0] E_D  = 6'b000001;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] op;
    logic [4:0] wr;
    logic       br;
    logic       mds;
    logic       mdd;
    logic       hilo;
    logic       rst;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [5:0] ex_opcode = '0;
  logic [4:0] ex_write_reg = '0;
  logic       ex_branch_taken = 1'b0;
  logic       id_md_start = 1'b0;
  logic       id_md_is_div = 1'b0;
  logic       id_uses_hilo = 1'b0;
  logic       pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_opcode       (ex_opcode),
    .ex_write_reg    (ex_write_reg),
    .ex_branch_taken (ex_branch_taken),
    .id_md_start     (id_md_start),
    .id_md_is_div    (id_md_is_div),
    .id_uses_hilo    (id_uses_hilo),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .md_busy         (md_busy),
    .md_done         (md_done)
  );

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [5:0] op, input logic [4:0] wr,
                               input logic br, input logic mds, input logic mdd,
                               input logic hilo, input logic rst);
    stim_t s;
    s = '{rs: rs, rt: rt, op: op, wr: wr, br: br, mds: mds, mdd: mdd, hilo: hilo, rst: rst};
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(5'd0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Inputs change on the falling edge; reset is asserted asynchronously there.
  task automatic drive(input stim_t s);
    @(negedge clk);
    id_rs           = s.rs;
    id_rt           = s.rt;
    ex_opcode       = s.op;
    ex_write_reg    = s.wr;
    ex_branch_taken = s.br;
    id_md_start     = s.mds;
    id_md_is_div    = s.mdd;
    id_uses_hilo    = s.hilo;
    rst_n           = !s.rst;
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E_N);
    st.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1)); ex.push_back(E_N);
    st.push_back(idle());                        ex.push_back(E_N);
    st.push_back(idle());                        ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL reset cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(5, 0, LW, 5, 0, 0, 0, 0, 0)); ex.push_back(E_ST);
    st.push_back(idle());                         ex.push_back(E_N);
    st.push_back(mk(0, 7, LW, 7, 0, 0, 0, 0, 0)); ex.push_back(E_ST);
    st.push_back(mk(3, 4, LW, 9, 0, 0, 0, 0, 0)); ex.push_back(E_N);
    st.push_back(mk(5, 5, SW, 5, 0, 0, 0, 0, 0)); ex.push_back(E_N);
    st.push_back(mk(0, 0, LW, 0, 0, 0, 0, 0, 0)); ex.push_back(E_N);
    st.push_back(mk(0, 3, LW, 0, 0, 0, 0, 0, 0)); ex.push_back(E_N);
    st.push_back(mk(31, 2, LW, 31, 0, 0, 0, 0, 0)); ex.push_back(E_ST);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL load_use cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_mult_mflo();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0)); ex.push_back(E_N);
    for (int k = 0; k < 4; k++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back(E_ST | E_B);
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back(E_N | E_D);
    st.push_back(idle());                        ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL mult_mflo cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_accept_block();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(5, 0, LW, 5, 0, 1, 0, 0, 0)); ex.push_back(E_ST);
    st.push_back(idle());                         ex.push_back(E_N);
    st.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));  ex.push_back(E_FL);
    st.push_back(idle());                         ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL accept_block cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_branch_priority();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(5, 0, LW, 5, 1, 0, 0, 0, 0)); ex.push_back(E_FL);
    st.push_back(idle());                         ex.push_back(E_N);
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));  ex.push_back(E_N);
    st.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));  ex.push_back(E_FL | E_B);
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back(E_ST | E_B);
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));  ex.push_back(E_N | E_D);
    st.push_back(idle());                         ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL branch_prio cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_div_branch();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0)); ex.push_back(E_N);
    for (int c = 1; c <= 32; c++) begin
      if (c == 3) begin
        st.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(E_FL | E_B);
      end else if (c == 10) begin
        st.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0)); ex.push_back(E_ST | E_B);
      end else if (c == 15) begin
        st.push_back(mk(5, 0, LW, 5, 0, 0, 0, 0, 0)); ex.push_back(E_ST | E_B);
      end else begin
        st.push_back(idle()); ex.push_back(E_N | E_B);
      end
    end
    st.push_back(idle()); ex.push_back(E_N | E_D);
    st.push_back(idle()); ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL div_branch cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0)); ex.push_back(E_N);
    for (int k = 0; k < 4; k++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0)); ex.push_back(E_ST | E_B);
    end
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0)); ex.push_back(E_N | E_D);
    for (int k = 0; k < 4; k++) begin
      st.push_back(idle()); ex.push_back(E_N | E_B);
    end
    st.push_back(idle()); ex.push_back(E_N | E_D);
    st.push_back(idle()); ex.push_back(E_N);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    stim_t st[$];
    logic [5:0] ex[$];
    logic [5:0] got, exp;
    st.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0)); ex.push_back(E_N);
    for (int k = 0; k < 10; k++) begin
      st.push_back(idle()); ex.push_back(E_N | E_B);
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E_N);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E_N);
    for (int k = 0; k < 36; k++) begin
      st.push_back(idle()); ex.push_back(E_N);
    end
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(ex[i]); #1;
      got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_busy, md_done};
      exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL reset_mid_div cyc %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mult_mflo();
    test_accept_block();
    test_branch_priority();
    test_div_branch();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
